contador_display: RTL and testbench
===================================

# contador_display

Downstream display stage for the 8-bit up/down counter. It takes the counter's unsigned 8-bit output and converts it to three BCD digits with a sequential shift-and-add-3 (double-dabble) engine. It then drives a time-multiplexed 3-digit common-anode 7-segment display with leading-zero blanking. Conversion runs continuously, so the display tracks the counter with a bounded lag.

## Interface
- REFRESH_DIV, default 1000: clocks per digit slot; legal range ≥ 2.
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- value  input  8  unsigned count from the counter (0..255).
- seg  output  7  segment drive, active-low; seg[0]=a … seg[6]=g.
- an  output  3  digit enables, active-low one-hot; an[0]=units, an[1]=tens, an[2]=hundreds.
- bcd  output  12  last completed conversion; [11:8] hundreds, [7:4] tens, [3:0] units.
- busy  output  1  high while a conversion is in SHIFT or DONE.

## Operation
- Reset is synchronous: rst is sampled only on posedge clk.
- Reset values:
  - state=IDLE, bcd=12'h000, busy=0.
  - Prescaler=0, digit index=0.
  - an=3'b110, seg=7'b1000000 (glyph '0').
- Converter FSM, three states:
  - IDLE: on the next edge, capture value into an 8-bit shift register, clear the 12-bit scratch, clear the iteration count, go to SHIFT.
  - SHIFT: each edge, first add 3 to every scratch nibble ≥ 5, then shift {scratch, shiftreg} left by 1. After the 8th shift, go to DONE.
  - DONE: on the next edge, load bcd from scratch and return to IDLE.
- Conversion cycle is 10 clocks per sample, back-to-back, with no idle gap beyond the IDLE state.
- value is sampled only on the IDLE→SHIFT edge. Changes during SHIFT/DONE are ignored until the next sample.
- Nibble adjust happens before the shift within the same cycle. Scratch nibbles never exceed 9 after a shift.
- Digit mux:
  - Prescaler counts 0..REFRESH_DIV-1.
  - On the edge where prescaler == REFRESH_DIV-1, the prescaler wraps to 0 and the index advances 0→1→2→0.
- Decode, for the selected digit d of bcd:
  - '0'=1000000, '1'=1111001, '2'=0100100, '3'=0110000, '4'=0011001
  - '5'=0010010, '6'=0000010, '7'=1111000, '8'=0000000, '9'=0010000
  - Patterns are written as seg[6:0].
  - Nibbles >9 cannot occur; if they did, drive blank (7'b1111111).
- Blanking:
  - Hundreds is blanked when it equals 0.
  - Tens is blanked when hundreds==0 and tens==0.
  - Units is never blanked.
  - A blanked digit keeps its an bit active and drives seg=7'b1111111.

## Timing
- Latency from the sample edge e0 to bcd update is 9 edges (written at e9).
- The next sample is at e10.
- busy:
  - Goes high at e0, i.e. from SHIFT entry.
  - Goes low at e9, on the same edge bcd updates.
  - Throughput is 1 conversion per 10 clocks.
- seg/an are registered and recomputed every clock from the current index and bcd. They reflect a change to either one clock later.
- A bcd update in the middle of a slot shows on seg one clock after the update.
- Reset during SHIFT/DONE:
  - The conversion is aborted and the partial result discarded.
  - bcd=0, and the FSM restarts from IDLE on the first edge after rst deasserts.
- Reset mid-slot restarts the prescaler at 0 and the index at 0.
- Simultaneous prescaler wrap and bcd update: the new index and new bcd both appear on seg/an at the following edge.

## Test plan
- rst high 3 clocks → bcd=000, busy=0, an=110, seg=1000000. First sample is on the edge after rst falls; busy is high for exactly 9 clocks.
- value=255 held → bcd=12'h255 at e9. With REFRESH_DIV=4, seg shows 0010010 / 0010010 / 0100100 for the units/tens/hundreds slots.
- value=0 → bcd=000; hundreds and tens slots give seg=1111111, units slot gives 1000000, and an still cycles 110→101→011.
- value=7 → tens and hundreds blank, units=1111000. value=100 → units '0' and tens '0' shown (not blanked), hundreds shows '1'=1111001.
- value changes from 42 to 99 two clocks after the sample edge → bcd=042 at e9. The next conversion then yields 099 at e19.
- rst asserted at e4 of converting 200 → bcd stays 000, the FSM restarts, and the following full conversion gives 200.

Source files
------------

// File: rtl/contador_display_if.sv
// Bundles the counter value feeding the display stage with the BCD result,
// the busy flag and the multiplexed 7-segment drive.
interface contador_display_if;
   logic [7:0]  value;
   logic [6:0]  seg;
   logic [2:0]  an;
   logic [11:0] bcd;
   logic        busy;

   modport master (output value, input seg, input an, input bcd, input busy);
   modport slave  (input value, output seg, output an, output bcd, output busy);
endinterface

// File: rtl/contador_display.sv
// Converts the 8-bit count to BCD with a sequential double-dabble engine and
// drives a 3-digit multiplexed common-anode 7-segment display with leading-zero blanking.
module contador_display #(
   parameter int REFRESH_DIV = 1000
) (
   input logic                clk,
   input logic                rst,
   contador_display_if.slave  bus
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state, state_next;
   logic [7:0]  shreg, shreg_next;
   logic [11:0] scratch, scratch_next, adj;
   logic [2:0]  iter, iter_next;
   logic [11:0] bcd_q, bcd_next;

   logic [PW-1:0] presc;
   logic [1:0]    idx;
   logic [6:0]    seg_q, seg_next;
   logic [2:0]    an_q, an_next;
   logic [3:0]    digit;
   logic          blank;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         shreg   <= '0;
         scratch <= '0;
         iter    <= '0;
         bcd_q   <= '0;
      end else begin
         state   <= state_next;
         shreg   <= shreg_next;
         scratch <= scratch_next;
         iter    <= iter_next;
         bcd_q   <= bcd_next;
      end
   end

   // Add-3 correction is applied before the shift so no nibble exceeds 9 afterwards.
   always_comb begin
      adj = scratch;
      for (int i = 0; i < 3; i++) begin
         if (scratch[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_next   = state;
      shreg_next   = shreg;
      scratch_next = scratch;
      iter_next    = iter;
      bcd_next     = bcd_q;
      case (state)
         IDLE: begin
            shreg_next   = bus.value;
            scratch_next = '0;
            iter_next    = '0;
            state_next   = SHIFT;
         end
         SHIFT: begin
            {scratch_next, shreg_next} = {adj, shreg} << 1;
            iter_next = iter + 3'd1;
            if (iter == 3'd7)
               state_next = DONE;
         end
         DONE: begin
            bcd_next   = scratch;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
         idx   <= '0;
         seg_q <= 7'b1000000;
         an_q  <= 3'b110;
      end else begin
         seg_q <= seg_next;
         an_q  <= an_next;
         if (presc == PW'(REFRESH_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
         end else begin
            presc <= presc + PW'(1);
         end
      end
   end

   // Leading-zero blanking looks at the higher digits of the whole result.
   always_comb begin
      digit = 4'd0;
      blank = 1'b1;
      an_next = 3'b111;
      case (idx)
         2'd0: begin
            digit   = bcd_q[3:0];
            blank   = 1'b0;
            an_next = 3'b110;
         end
         2'd1: begin
            digit   = bcd_q[7:4];
            blank   = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
            an_next = 3'b101;
         end
         2'd2: begin
            digit   = bcd_q[11:8];
            blank   = (bcd_q[11:8] == 4'd0);
            an_next = 3'b011;
         end
         default: ;
      endcase
   end

   always_comb begin
      seg_next = 7'b1111111;
      if (!blank) begin
         case (digit)
            4'd0: seg_next = 7'b1000000;
            4'd1: seg_next = 7'b1111001;
            4'd2: seg_next = 7'b0100100;
            4'd3: seg_next = 7'b0110000;
            4'd4: seg_next = 7'b0011001;
            4'd5: seg_next = 7'b0010010;
            4'd6: seg_next = 7'b0000010;
            4'd7: seg_next = 7'b1111000;
            4'd8: seg_next = 7'b0000000;
            4'd9: seg_next = 7'b0010000;
            default: seg_next = 7'b1111111;
         endcase
      end
   end

   assign bus.bcd  = bcd_q;
   assign bus.busy = (state == SHIFT) || (state == DONE);
   assign bus.seg  = seg_q;
   assign bus.an   = an_q;

endmodule

// File: tb/tb_contador_display.sv
// Directed and randomized bench for contador_display against a decimal-arithmetic
// model of the conversion cycle and the multiplexed display.
module tb_contador_display;

   localparam int DIV = 4;

   logic clk = 1'b0;
   logic rst;

   contador_display_if bus ();

   contador_display #(.REFRESH_DIV(DIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int m_phase, m_pend, m_val, m_presc, m_idx;
   logic [6:0] exp_seg;
   logic [2:0] exp_an;
   logic       exp_busy;

   logic [6:0] glyph_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   function automatic logic [11:0] to_bcd(int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [6:0] glyph(int slot, int v);
      int d;
      bit bl;
      case (slot)
         0:       begin d = v % 10;        bl = 1'b0;     end
         1:       begin d = (v / 10) % 10; bl = (v < 10);  end
         default: begin d = v / 100;       bl = (v < 100); end
      endcase
      return bl ? 7'b1111111 : glyph_tab[d];
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_output();
      check("bcd",  32'(bus.bcd),  32'(to_bcd(m_val)));
      check("busy", 32'(bus.busy), 32'(exp_busy));
      check("seg",  32'(bus.seg),  32'(exp_seg));
      check("an",   32'(bus.an),   32'(exp_an));
   endtask

   // One clock edge: advance the model from the inputs seen at the edge, then compare.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_phase  = 0;
         m_val    = 0;
         m_presc  = 0;
         m_idx    = 0;
         exp_seg  = 7'b1000000;
         exp_an   = 3'b110;
         exp_busy = 1'b0;
      end else begin
         exp_seg = glyph(m_idx, m_val);
         exp_an  = ~(3'b001 << m_idx);
         if (m_presc == DIV - 1) begin
            m_presc = 0;
            m_idx   = (m_idx + 1) % 3;
         end else begin
            m_presc++;
         end
         if (m_phase == 0) m_pend = int'(bus.value);
         if (m_phase == 9) m_val = m_pend;
         exp_busy = (m_phase != 9);
         m_phase  = (m_phase + 1) % 10;
      end
      #1;
      check_output();
   endtask

   task automatic apply_stimulus(int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic align();
      for (int k = 0; k < 10 && m_phase != 0; k++) tick();
   endtask

   initial begin
      m_phase = 0; m_pend = 0; m_val = 0; m_presc = 0; m_idx = 0;
      exp_seg = 7'b1000000; exp_an = 3'b110; exp_busy = 1'b0;
      rst = 1'b1;
      bus.value = 8'($urandom_range(0, 255));
      #2;
      apply_stimulus(3);
      check("rst_bcd",  32'(bus.bcd),  32'h000);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_an",   32'(bus.an),   32'b110);
      check("rst_seg",  32'(bus.seg),  32'b1000000);

      $display("[TB] value 255");
      rst = 1'b0;
      bus.value = 8'd255;
      apply_stimulus(9);
      check("busy_e8", 32'(bus.busy), 32'h1);
      tick();
      check("bcd_255",  32'(bus.bcd),  32'h255);
      check("busy_e9",  32'(bus.busy), 32'h0);
      apply_stimulus(24);

      $display("[TB] values 0, 7, 100");
      bus.value = 8'd0;
      apply_stimulus(24);
      check("bcd_000", 32'(bus.bcd), 32'h000);
      bus.value = 8'd7;
      apply_stimulus(24);
      check("bcd_007", 32'(bus.bcd), 32'h007);
      bus.value = 8'd100;
      apply_stimulus(24);
      check("bcd_100", 32'(bus.bcd), 32'h100);

      $display("[TB] value change during conversion");
      align();
      bus.value = 8'd42;
      apply_stimulus(2);
      bus.value = 8'd99;
      apply_stimulus(8);
      check("bcd_042", 32'(bus.bcd), 32'h042);
      apply_stimulus(10);
      check("bcd_099", 32'(bus.bcd), 32'h099);

      $display("[TB] reset mid conversion");
      align();
      bus.value = 8'd200;
      apply_stimulus(4);
      rst = 1'b1;
      tick();
      check("abort_bcd",  32'(bus.bcd),  32'h000);
      check("abort_busy", 32'(bus.busy), 32'h0);
      rst = 1'b0;
      apply_stimulus(9);
      check("abort_mid", 32'(bus.bcd), 32'h000);
      tick();
      check("bcd_200", 32'(bus.bcd), 32'h200);

      $display("[TB] randomized values");
      for (int k = 0; k < 300; k++) begin
         bus.value = 8'($urandom_range(0, 255));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
